// File: rtl/v850_decode_issue_if.sv
// Fetch-side handshake and executer-side issue bus of the decode/issue stage.
interface v850_decode_issue_if;
    logic [15:0] fetch_hw_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic        flush_i;
    logic [4:0]  destination_o;
    logic [31:0] reg1_o;
    logic [31:0] reg2_o;
    logic [31:0] reg3_o;
    logic        increment_bit_o;
    logic [9:0]  circuit_sel_o;
    logic        issue_valid_o;
    logic        illegal_o;

    // Decode/issue stage side
    modport slave (
        input  fetch_hw_i, fetch_valid_i, flush_i,
        output fetch_ready_o, destination_o, reg1_o, reg2_o, reg3_o,
               increment_bit_o, circuit_sel_o, issue_valid_o, illegal_o
    );

    // Fetch / executer environment side
    modport master (
        output fetch_hw_i, fetch_valid_i, flush_i,
        input  fetch_ready_o, destination_o, reg1_o, reg2_o, reg3_o,
               increment_bit_o, circuit_sel_o, issue_valid_o, illegal_o
    );
endinterface

// File: rtl/v850_decode_issue.sv
// V850 decode/issue stage: assembles 16/32-bit instructions from a halfword
// stream, reads operands and drives the integer executer through registers,
// inserting a one-cycle bubble on read-after-write hazards.
module v850_decode_issue #(
    parameter logic [9:0] NOP_SEL = 10'h004
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0][31:0] gr_i,
    v850_decode_issue_if.slave bus
);
    localparam int unsigned HW_W   = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned SEL_W  = 10;

    typedef enum logic [1:0] {
        S_FIRST  = 2'd0,
        S_SECOND = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [HW_W-1:0]     hw1_q, hw1_d;
    logic [HW_W-1:0]     imm_q, imm_d;
    logic [REG_W-1:0]    last_dest_q, last_dest_d;
    logic                last_vld_q, last_vld_d;

    logic [REG_W-1:0]    dest_q, dest_d;
    logic [DATA_W-1:0]   reg1_q, reg1_d;
    logic [DATA_W-1:0]   reg2_q, reg2_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                issue_valid_q, issue_valid_d;
    logic                illegal_q, illegal_d;

    logic [HW_W-1:0]     cur_hw, cur_imm;
    logic [REG_W-1:0]    r1, r2;
    logic [5:0]          op;
    logic [DATA_W-1:0]   gr_r1, gr_r2;
    logic                dec_legal, dec_writes, use_r1, use_r2;
    logic [SEL_W-1:0]    dec_sel;
    logic [DATA_W-1:0]   dec_op1, dec_op2;
    logic                is32, hazard, accept, issue;

    assign bus.fetch_ready_o = !bus.flush_i && (state_q != S_HOLD);
    assign accept            = bus.fetch_valid_i && bus.fetch_ready_o;

    // Select the halfword pair being decoded this cycle
    always_comb begin
        cur_hw  = hw1_q;
        cur_imm = imm_q;
        if (state_q == S_FIRST) begin
            cur_hw = bus.fetch_hw_i;
        end else if (state_q == S_SECOND) begin
            cur_imm = bus.fetch_hw_i;
        end
    end

    assign r2    = cur_hw[15:11];
    assign op    = cur_hw[10:5];
    assign r1    = cur_hw[4:0];
    assign is32  = (op[5:4] == 2'b11);
    assign gr_r1 = (r1 == REG_W'(0)) ? DATA_W'(0) : gr_i[r1];
    assign gr_r2 = (r2 == REG_W'(0)) ? DATA_W'(0) : gr_i[r2];

    // Opcode map: function select, operands and which sources are read
    always_comb begin
        dec_legal  = 1'b1;
        dec_writes = 1'b1;
        use_r1     = 1'b1;
        use_r2     = 1'b1;
        dec_sel    = NOP_SEL;
        dec_op1    = gr_r1;
        dec_op2    = gr_r2;
        case (op)
            6'b001110: dec_sel = SEL_W'(10'h020);
            6'b010010: begin
                dec_sel = SEL_W'(10'h020);
                dec_op1 = {{(DATA_W-5){r1[4]}}, r1};
                use_r1  = 1'b0;
            end
            6'b001101: begin
                dec_sel = SEL_W'(10'h000);
                dec_op1 = (~gr_r1) + DATA_W'(1);
            end
            6'b001111: begin
                dec_sel    = SEL_W'(10'h000);
                dec_op1    = (~gr_r1) + DATA_W'(1);
                dec_writes = 1'b0;
            end
            6'b001010: dec_sel = SEL_W'(10'h002);
            6'b001000: dec_sel = SEL_W'(10'h003);
            6'b010101: begin
                dec_sel = SEL_W'(10'h040);
                dec_op1 = DATA_W'(r1);
                use_r1  = 1'b0;
            end
            6'b110000: begin
                dec_sel = SEL_W'(10'h020);
                dec_op2 = {{(DATA_W-HW_W){cur_imm[15]}}, cur_imm};
                use_r2  = 1'b0;
            end
            6'b110001: begin
                dec_sel = SEL_W'(10'h021);
                dec_op2 = {{(DATA_W-HW_W){cur_imm[15]}}, cur_imm};
                use_r2  = 1'b0;
            end
            6'b110100: begin
                dec_sel = SEL_W'(10'h003);
                dec_op2 = DATA_W'(cur_imm);
                use_r2  = 1'b0;
            end
            6'b110110: begin
                dec_sel = SEL_W'(10'h002);
                dec_op2 = DATA_W'(cur_imm);
                use_r2  = 1'b0;
            end
            default: begin
                dec_legal  = 1'b0;
                dec_writes = 1'b0;
                use_r1     = 1'b0;
                use_r2     = 1'b0;
            end
        endcase
    end

    // RAW hazard against the instruction currently on the outputs
    assign hazard = last_vld_q &&
                    ((use_r1 && (r1 == last_dest_q)) || (use_r2 && (r2 == last_dest_q)));

    // Next-state, holding registers and next output values
    always_comb begin
        state_d       = state_q;
        hw1_d         = hw1_q;
        imm_d         = imm_q;
        issue         = 1'b0;
        dest_d        = REG_W'(0);
        reg1_d        = DATA_W'(0);
        reg2_d        = DATA_W'(0);
        sel_d         = NOP_SEL;
        issue_valid_d = 1'b0;
        illegal_d     = 1'b0;
        last_dest_d   = REG_W'(0);
        last_vld_d    = 1'b0;

        case (state_q)
            S_FIRST: begin
                if (accept) begin
                    if (is32) begin
                        hw1_d   = bus.fetch_hw_i;
                        state_d = S_SECOND;
                    end else if (hazard) begin
                        hw1_d   = bus.fetch_hw_i;
                        state_d = S_HOLD;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            S_SECOND: begin
                if (accept) begin
                    if (hazard) begin
                        imm_d   = bus.fetch_hw_i;
                        state_d = S_HOLD;
                    end else begin
                        issue   = 1'b1;
                        state_d = S_FIRST;
                    end
                end
            end
            S_HOLD: begin
                issue   = 1'b1;
                state_d = S_FIRST;
            end
            default: state_d = S_FIRST;
        endcase

        if (bus.flush_i) begin
            issue   = 1'b0;
            state_d = S_FIRST;
        end

        if (issue) begin
            if (!dec_legal) begin
                illegal_d = 1'b1;
            end else if (dec_writes && (r2 == REG_W'(0))) begin
                issue_valid_d = 1'b1;
            end else begin
                issue_valid_d = 1'b1;
                sel_d         = dec_sel;
                reg1_d        = dec_op1;
                reg2_d        = dec_op2;
                dest_d        = dec_writes ? r2 : REG_W'(0);
                last_dest_d   = r2;
                last_vld_d    = dec_writes;
            end
        end
    end

    // State, holding and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FIRST;
            hw1_q         <= HW_W'(0);
            imm_q         <= HW_W'(0);
            last_dest_q   <= REG_W'(0);
            last_vld_q    <= 1'b0;
            dest_q        <= REG_W'(0);
            reg1_q        <= DATA_W'(0);
            reg2_q        <= DATA_W'(0);
            sel_q         <= NOP_SEL;
            issue_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hw1_q         <= hw1_d;
            imm_q         <= imm_d;
            last_dest_q   <= last_dest_d;
            last_vld_q    <= last_vld_d;
            dest_q        <= dest_d;
            reg1_q        <= reg1_d;
            reg2_q        <= reg2_d;
            sel_q         <= sel_d;
            issue_valid_q <= issue_valid_d;
            illegal_q     <= illegal_d;
        end
    end

    assign bus.destination_o   = dest_q;
    assign bus.reg1_o          = reg1_q;
    assign bus.reg2_o          = reg2_q;
    assign bus.reg3_o          = DATA_W'(0);
    assign bus.increment_bit_o = 1'b0;
    assign bus.circuit_sel_o   = sel_q;
    assign bus.issue_valid_o   = issue_valid_q;
    assign bus.illegal_o       = illegal_q;
endmodule

// File: tb/tb_v850_decode_issue.sv
// Directed bench for the V850 decode/issue stage.
module tb_v850_decode_issue;
    logic              clk;
    logic              rst;
    logic [31:0][31:0] gr;
    int                vec_cnt;
    int                err_cnt;

    v850_decode_issue_if bus ();

    v850_decode_issue dut (
        .clk  (clk),
        .rst  (rst),
        .gr_i (gr),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and return at the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [15:0] hw);
        bus.fetch_hw_i    = hw;
        bus.fetch_valid_i = 1'b1;
        step();
        bus.fetch_valid_i = 1'b0;
    endtask

    task automatic idle();
        bus.fetch_valid_i = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst               = 1'b1;
        bus.flush_i       = 1'b0;
        bus.fetch_hw_i    = 16'h11C1;
        bus.fetch_valid_i = 1'b1;
        gr                = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst               = 1'b0;
        bus.fetch_valid_i = 1'b0;
        vec_cnt++;
        if (bus.circuit_sel_o !== 10'h004) begin
            err_cnt++; $display("FAIL reset_sel: got %h want 004", bus.circuit_sel_o);
        end
        vec_cnt++;
        if ({bus.issue_valid_o, bus.illegal_o, bus.destination_o} !== 7'd0) begin
            err_cnt++; $display("FAIL reset_flags: got v=%b i=%b d=%0d want 0", bus.issue_valid_o, bus.illegal_o, bus.destination_o);
        end
        vec_cnt++;
        if ({bus.reg1_o, bus.reg2_o, bus.reg3_o, bus.increment_bit_o} !== 97'd0) begin
            err_cnt++; $display("FAIL reset_ops: got %h %h %h %b want zeros", bus.reg1_o, bus.reg2_o, bus.reg3_o, bus.increment_bit_o);
        end
        vec_cnt++;
        if (bus.fetch_ready_o !== 1'b1) begin
            err_cnt++; $display("FAIL reset_ready: got %b want 1", bus.fetch_ready_o);
        end
    endtask

    task automatic test_add();
        gr[1] = 32'd5; gr[2] = 32'd7;
        drive(16'h11C1);
        vec_cnt++;
        if ({bus.circuit_sel_o, bus.destination_o, bus.issue_valid_o} !== {10'h020, 5'd2, 1'b1}) begin
            err_cnt++; $display("FAIL add_ctl: got sel=%h d=%0d v=%b want 020 2 1", bus.circuit_sel_o, bus.destination_o, bus.issue_valid_o);
        end
        vec_cnt++;
        if ({bus.reg1_o, bus.reg2_o} !== {32'd5, 32'd7}) begin
            err_cnt++; $display("FAIL add_ops: got %h %h want 5 7", bus.reg1_o, bus.reg2_o);
        end
        vec_cnt++;
        if ({bus.reg3_o, bus.increment_bit_o} !== 33'd0) begin
            err_cnt++; $display("FAIL add_zero: got %h %b want 0 0", bus.reg3_o, bus.increment_bit_o);
        end
        idle();
        vec_cnt++;
        if ({bus.circuit_sel_o, bus.issue_valid_o} !== {10'h004, 1'b0}) begin
            err_cnt++; $display("FAIL idle_nop: got sel=%h v=%b want 004 0", bus.circuit_sel_o, bus.issue_valid_o);
        end
    endtask

    task automatic test_addi();
        gr[1] = 32'd9;
        drive(16'h1E01);
        vec_cnt++;
        if ({bus.circuit_sel_o, bus.issue_valid_o, bus.fetch_ready_o} !== {10'h004, 1'b0, 1'b1}) begin
            err_cnt++; $display("FAIL addi_first: got sel=%h v=%b rdy=%b want 004 0 1", bus.circuit_sel_o, bus.issue_valid_o, bus.fetch_ready_o);
        end
        drive(16'hFFFF);
        vec_cnt++;
        if ({bus.circuit_sel_o, bus.destination_o, bus.issue_valid_o} !== {10'h020, 5'd3, 1'b1}) begin
            err_cnt++; $display("FAIL addi_ctl: got sel=%h d=%0d v=%b want 020 3 1", bus.circuit_sel_o, bus.destination_o, bus.issue_valid_o);
        end
        vec_cnt++;
        if ({bus.reg1_o, bus.reg2_o} !== {32'd9, 32'hFFFF_FFFF}) begin
            err_cnt++; $display("FAIL addi_ops: got %h %h want 9 ffffffff", bus.reg1_o, bus.reg2_o);
        end
        idle();
    endtask

    task automatic test_hazard();
        gr[1] = 32'd5; gr[2] = 32'd7; gr[3] = 32'd20;
        drive(16'h11C1);
        bus.fetch_hw_i    = 16'h1942;
        bus.fetch_valid_i = 1'b1;
        step();
        bus.fetch_valid_i = 1'b0;
        vec_cnt++;
        if ({bus.circuit_sel_o, bus.issue_valid_o, bus.fetch_ready_o} !== {10'h004, 1'b0, 1'b0}) begin
            err_cnt++; $display("FAIL hazard_bubble: got sel=%h v=%b rdy=%b want 004 0 0", bus.circuit_sel_o, bus.issue_valid_o, bus.fetch_ready_o);
        end
        gr[2] = 32'd12;
        step();
        vec_cnt++;
        if ({bus.circuit_sel_o, bus.destination_o, bus.issue_valid_o} !== {10'h002, 5'd3, 1'b1}) begin
            err_cnt++; $display("FAIL hazard_ctl: got sel=%h d=%0d v=%b want 002 3 1", bus.circuit_sel_o, bus.destination_o, bus.issue_valid_o);
        end
        vec_cnt++;
        if ({bus.reg1_o, bus.reg2_o} !== {32'd12, 32'd20}) begin
            err_cnt++; $display("FAIL hazard_ops: got %h %h want c 14", bus.reg1_o, bus.reg2_o);
        end
        vec_cnt++;
        if (bus.fetch_ready_o !== 1'b1) begin
            err_cnt++; $display("FAIL hazard_ready: got %b want 1", bus.fetch_ready_o);
        end
        idle();
    endtask

    task automatic test_sub();
        gr[1] = 32'd3; gr[2] = 32'd7;
        drive(16'h11A1);
        vec_cnt++;
        if ({bus.circuit_sel_o, bus.destination_o, bus.reg1_o, bus.reg2_o} !== {10'h000, 5'd2, 32'hFFFF_FFFD, 32'd7}) begin
            err_cnt++; $display("FAIL sub: got sel=%h d=%0d r1=%h r2=%h want 000 2 fffffffd 7", bus.circuit_sel_o, bus.destination_o, bus.reg1_o, bus.reg2_o);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        gr[1] = 32'd3; gr[2] = 32'd7; gr[3] = 32'd20;
        drive(16'h11E1);
        vec_cnt++;
        if ({bus.circuit_sel_o, bus.destination_o, bus.reg1_o, bus.issue_valid_o} !== {10'h000, 5'd0, 32'hFFFF_FFFD, 1'b1}) begin
            err_cnt++; $display("FAIL cmp: got sel=%h d=%0d r1=%h v=%b want 000 0 fffffffd 1", bus.circuit_sel_o, bus.destination_o, bus.reg1_o, bus.issue_valid_o);
        end
        drive(16'h1942);
        vec_cnt++;
        if ({bus.circuit_sel_o, bus.destination_o, bus.reg1_o, bus.reg2_o} !== {10'h002, 5'd3, 32'd7, 32'd20}) begin
            err_cnt++; $display("FAIL cmp_and: got sel=%h d=%0d r1=%h r2=%h want 002 3 7 14", bus.circuit_sel_o, bus.destination_o, bus.reg1_o, bus.reg2_o);
        end
        idle();
        drive(16'h01C1);
        vec_cnt++;
        if ({bus.circuit_sel_o, bus.destination_o, bus.reg1_o, bus.issue_valid_o, bus.illegal_o} !== {10'h004, 5'd0, 32'd0, 1'b1, 1'b0}) begin
            err_cnt++; $display("FAIL r0_dest: got sel=%h d=%0d r1=%h v=%b il=%b want 004 0 0 1 0", bus.circuit_sel_o, bus.destination_o, bus.reg1_o, bus.issue_valid_o, bus.illegal_o);
        end
        drive(16'h2681);
        drive(16'h8001);
        vec_cnt++;
        if ({bus.circuit_sel_o, bus.destination_o, bus.reg1_o, bus.reg2_o} !== {10'h003, 5'd4, 32'd3, 32'h0000_8001}) begin
            err_cnt++; $display("FAIL ori: got sel=%h d=%0d r1=%h r2=%h want 003 4 3 8001", bus.circuit_sel_o, bus.destination_o, bus.reg1_o, bus.reg2_o);
        end
        idle();
        drive(16'h12BF);
        vec_cnt++;
        if ({bus.circuit_sel_o, bus.destination_o, bus.reg1_o, bus.reg2_o} !== {10'h040, 5'd2, 32'h1F, 32'd7}) begin
            err_cnt++; $display("FAIL sar: got sel=%h d=%0d r1=%h r2=%h want 040 2 1f 7", bus.circuit_sel_o, bus.destination_o, bus.reg1_o, bus.reg2_o);
        end
        idle();
        drive(16'h125F);
        vec_cnt++;
        if ({bus.circuit_sel_o, bus.destination_o, bus.reg1_o} !== {10'h020, 5'd2, 32'hFFFF_FFFF}) begin
            err_cnt++; $display("FAIL add_imm5: got sel=%h d=%0d r1=%h want 020 2 ffffffff", bus.circuit_sel_o, bus.destination_o, bus.reg1_o);
        end
        idle();
    endtask

    task automatic test_flush();
        gr[1] = 32'd5; gr[2] = 32'd7;
        drive(16'h1E01);
        bus.flush_i = 1'b1;
        #1;
        vec_cnt++;
        if (bus.fetch_ready_o !== 1'b0) begin
            err_cnt++; $display("FAIL flush_ready: got %b want 0", bus.fetch_ready_o);
        end
        step();
        bus.flush_i = 1'b0;
        drive(16'h11C1);
        vec_cnt++;
        if ({bus.circuit_sel_o, bus.destination_o, bus.reg2_o, bus.illegal_o} !== {10'h020, 5'd2, 32'd7, 1'b0}) begin
            err_cnt++; $display("FAIL flush_add: got sel=%h d=%0d r2=%h il=%b want 020 2 7 0", bus.circuit_sel_o, bus.destination_o, bus.reg2_o, bus.illegal_o);
        end
        idle();
    endtask

    task automatic test_illegal();
        drive(16'h0821);
        vec_cnt++;
        if ({bus.illegal_o, bus.circuit_sel_o, bus.issue_valid_o} !== {1'b1, 10'h004, 1'b0}) begin
            err_cnt++; $display("FAIL illegal16: got il=%b sel=%h v=%b want 1 004 0", bus.illegal_o, bus.circuit_sel_o, bus.issue_valid_o);
        end
        idle();
        vec_cnt++;
        if (bus.illegal_o !== 1'b0) begin
            err_cnt++; $display("FAIL illegal_pulse: got %b want 0", bus.illegal_o);
        end
        drive(16'h0FE0);
        vec_cnt++;
        if (bus.illegal_o !== 1'b0) begin
            err_cnt++; $display("FAIL illegal32_first: got %b want 0", bus.illegal_o);
        end
        drive(16'h1234);
        vec_cnt++;
        if ({bus.illegal_o, bus.circuit_sel_o, bus.issue_valid_o} !== {1'b1, 10'h004, 1'b0}) begin
            err_cnt++; $display("FAIL illegal32: got il=%b sel=%h v=%b want 1 004 0", bus.illegal_o, bus.circuit_sel_o, bus.issue_valid_o);
        end
        idle();
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_add();
        test_addi();
        test_hazard();
        test_sub();
        test_back_to_back();
        test_flush();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
